// File: rtl/mem_secded_scrub.sv
// SEC-DED (extended Hamming) register-file memory with an idle-time background scrubber.
// Optional build macro MEM_ERR_INJECT_EN adds inj_mask, XORed into codewords on host writes.
module mem_secded_scrub #(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 4,
  parameter int SCRUB_INTERVAL = 256,
  localparam int PAR_W = $clog2(DATA_W + 1 + $clog2(DATA_W + 1 + $clog2(DATA_W + 1))),
  localparam int CW_W  = DATA_W + PAR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              err_corr,
  output logic              err_uncorr,
  output logic              scrub_busy,
  output logic              scrub_uncorr,
  output logic [7:0]        corr_count
`ifdef MEM_ERR_INJECT_EN
  ,
  input  logic [CW_W-1:0]   inj_mask
`endif
);

  // state    | meaning
  // IDLE     | counting idle cycles until the next scrub step
  // SCRUB_RD | decode mem[scrub_ptr] on the first cycle without host access
  // SCRUB_WB | write back the corrected codeword on the first free cycle

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = $clog2(SCRUB_INTERVAL);

  typedef enum logic [1:0] {IDLE, SCRUB_RD, SCRUB_WB} state_t;

  typedef struct packed {
    logic [CW_W-1:0] cw;
    logic            corr;
    logic            uncorr;
  } dec_t;

  function automatic logic [CW_W-1:0] encode(input logic [DATA_W-1:0] d);
    logic [CW_W-1:0] cw;
    logic            p;
    int              j;
    cw = '0;
    j  = 0;
    for (int pos = 1; pos < CW_W; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos-1] = d[j];
        j++;
      end
    end
    for (int k = 0; k < PAR_W; k++) begin
      p = 1'b0;
      for (int pos = 1; pos < CW_W; pos++) begin
        if (pos[k]) p = p ^ cw[pos-1];
      end
      cw[(1 << k) - 1] = p;
    end
    cw[CW_W-1] = ^cw[CW_W-2:0];
    return cw;
  endfunction

  // A syndrome beyond the last Hamming position can only come from 3+ flips.
  function automatic dec_t decode(input logic [CW_W-1:0] cw);
    dec_t             r;
    logic [PAR_W-1:0] syn;
    logic             ovf;
    syn = '0;
    for (int pos = 1; pos < CW_W; pos++) begin
      if (cw[pos-1]) syn = syn ^ PAR_W'(pos);
    end
    ovf      = ^cw;
    r.cw     = cw;
    r.corr   = 1'b0;
    r.uncorr = 1'b0;
    if (ovf) begin
      if (syn == '0) begin
        r.cw[CW_W-1] = ~cw[CW_W-1];
        r.corr       = 1'b1;
      end else if (int'(syn) < CW_W) begin
        r.cw[int'(syn) - 1] = ~cw[int'(syn) - 1];
        r.corr              = 1'b1;
      end else begin
        r.uncorr = 1'b1;
      end
    end else if (syn != '0) begin
      r.uncorr = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] extract(input logic [CW_W-1:0] cw);
    logic [DATA_W-1:0] d;
    int                j;
    d = '0;
    j = 0;
    for (int pos = 1; pos < CW_W; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        d[j] = cw[pos-1];
        j++;
      end
    end
    return d;
  endfunction

  logic [CW_W-1:0]   mem [DEPTH];
  logic [CW_W-1:0]   wr_cw;
  logic [CW_W-1:0]   wb_cw;
  logic [ADDR_W-1:0] scrub_ptr;
  logic [CNT_W-1:0]  interval_cnt;
  state_t            state;
  dec_t              host_dec;
  dec_t              scrub_dec;
  logic              host_corr;
  logic              wb_fire;
  logic              wb_abandon;
  logic [8:0]        cnt_sum;

  assign host_dec  = decode(mem[addr]);
  assign scrub_dec = decode(mem[scrub_ptr]);

`ifdef MEM_ERR_INJECT_EN
  assign wr_cw = encode(wdata) ^ inj_mask;
`else
  assign wr_cw = encode(wdata);
`endif

  assign host_corr  = rd_en & host_dec.corr;
  assign wb_fire    = (state == SCRUB_WB) & ~wr_en & ~rd_en;
  assign wb_abandon = (state == SCRUB_WB) & wr_en & (addr == scrub_ptr);
  assign cnt_sum    = {1'b0, corr_count} + 9'(host_corr) + 9'(wb_fire);

  // Write-back only fires on host-idle cycles, so the two write sources never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[addr] <= wr_cw;
    end else if (wb_fire) begin
      mem[scrub_ptr] <= wb_cw;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata      <= '0;
      rvalid     <= 1'b0;
      err_corr   <= 1'b0;
      err_uncorr <= 1'b0;
      corr_count <= '0;
    end else begin
      rvalid     <= rd_en;
      err_corr   <= host_corr;
      err_uncorr <= rd_en & host_dec.uncorr;
      if (rd_en) rdata <= extract(host_dec.cw);
      corr_count <= cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      interval_cnt <= '0;
      scrub_ptr    <= '0;
      wb_cw        <= '0;
      scrub_busy   <= 1'b0;
      scrub_uncorr <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (interval_cnt == CNT_W'(SCRUB_INTERVAL - 1)) begin
            interval_cnt <= '0;
            state        <= SCRUB_RD;
            scrub_busy   <= 1'b1;
          end else begin
            interval_cnt <= interval_cnt + 1'b1;
          end
        end
        SCRUB_RD: begin
          if (!(wr_en | rd_en)) begin
            if (scrub_dec.corr) begin
              wb_cw <= scrub_dec.cw;
              state <= SCRUB_WB;
            end else begin
              if (scrub_dec.uncorr) scrub_uncorr <= 1'b1;
              scrub_ptr  <= scrub_ptr + 1'b1;
              state      <= IDLE;
              scrub_busy <= 1'b0;
            end
          end
        end
        SCRUB_WB: begin
          if (wb_fire | wb_abandon) begin
            scrub_ptr  <= scrub_ptr + 1'b1;
            state      <= IDLE;
            scrub_busy <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          scrub_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_secded_scrub.sv
// Randomised self-checking bench for mem_secded_scrub against a data + flipped-bit-set memory model.
// Error-injection scenarios run only when MEM_ERR_INJECT_EN is defined for the build.
module tb_mem_secded_scrub;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int CW    = 13;
  localparam int DEPTH = 16;
`ifdef MEM_ERR_INJECT_EN
  localparam bit INJ = 1'b1;
`else
  localparam bit INJ = 1'b0;
`endif

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] addr  = '0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          err_corr;
  logic          err_uncorr;
  logic          scrub_busy;
  logic          scrub_uncorr;
  logic [7:0]    corr_count;
`ifdef MEM_ERR_INJECT_EN
  logic [CW-1:0] inj_mask = '0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // model: payload per word plus the set of codeword bits flipped relative to a clean encoding
  logic [DW-1:0] md [DEPTH];
  logic [CW-1:0] mm [DEPTH];
  int            m_cnt;
  bit            m_su;
  int            dpos [DW];

  always #5 clk = ~clk;

  mem_secded_scrub #(.DATA_W(DW), .ADDR_W(AW), .SCRUB_INTERVAL(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(wr_en),
    .rd_en(rd_en),
    .addr(addr),
    .wdata(wdata),
    .rdata(rdata),
    .rvalid(rvalid),
    .err_corr(err_corr),
    .err_uncorr(err_uncorr),
    .scrub_busy(scrub_busy),
    .scrub_uncorr(scrub_uncorr),
    .corr_count(corr_count)
`ifdef MEM_ERR_INJECT_EN
    , .inj_mask(inj_mask)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      md[i] = '0;
      mm[i] = '0;
    end
    m_cnt = 0;
    m_su  = 1'b0;
  endfunction

  function automatic logic [DW-1:0] raw_data(input int a);
    logic [DW-1:0] d;
    for (int i = 0; i < DW; i++) d[i] = md[a][i] ^ mm[a][dpos[i]-1];
    return d;
  endfunction

  function automatic logic [CW-1:0] rand_mask();
    logic [CW-1:0] m;
    int w;
    int p1;
    int p2;
    m  = '0;
    w  = $urandom_range(2);
    p1 = $urandom_range(CW - 1);
    p2 = p1;
    if (w >= 1) m[p1] = 1'b1;
    if (w == 2) begin
      while (p2 == p1) p2 = $urandom_range(CW - 1);
      m[p2] = 1'b1;
    end
    return m;
  endfunction

  task automatic step(input bit we, input bit re, input int a, input logic [DW-1:0] d,
                      input logic [CW-1:0] m);
    int            w;
    logic [DW-1:0] e_data;
    w      = $countones(mm[a]);
    e_data = (w == 2) ? raw_data(a) : md[a];
    if (re && w == 1 && m_cnt < 255) m_cnt++;
    wr_en = we;
    rd_en = re;
    addr  = a[AW-1:0];
    wdata = d;
`ifdef MEM_ERR_INJECT_EN
    inj_mask = m;
`endif
    if (we) begin
      md[a] = d;
      mm[a] = INJ ? m : '0;
    end
    @(negedge clk);
    chk($sformatf("rvalid@%0d", a), 32'(rvalid), 32'(re));
    if (re) begin
      chk($sformatf("rdata@%0d", a), 32'(rdata), 32'(e_data));
      chk($sformatf("err_corr@%0d", a), 32'(err_corr), 32'(w == 1));
      chk($sformatf("err_uncorr@%0d", a), 32'(err_uncorr), 32'(w == 2));
    end
    chk("corr_count", 32'(corr_count), m_cnt);
  endtask

  task automatic idle(input int n);
    wr_en = 1'b0;
    rd_en = 1'b0;
    repeat (n) @(negedge clk);
    chk("idle_rvalid", 32'(rvalid), 0);
  endtask

  // long enough for the scrubber to visit every address at least once
  task automatic sweep();
    int w;
    wr_en = 1'b0;
    rd_en = 1'b0;
    repeat (400) @(negedge clk);
    for (int a = 0; a < DEPTH; a++) begin
      w = $countones(mm[a]);
      if (w == 1) begin
        if (m_cnt < 255) m_cnt++;
        mm[a] = '0;
      end else if (w == 2) begin
        m_su = 1'b1;
      end
    end
    chk("sweep_corr_count", 32'(corr_count), m_cnt);
    chk("sweep_scrub_uncorr", 32'(scrub_uncorr), 32'(m_su));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_rdata"}, 32'(rdata), 0);
    chk({tag, "_rvalid"}, 32'(rvalid), 0);
    chk({tag, "_err_corr"}, 32'(err_corr), 0);
    chk({tag, "_err_uncorr"}, 32'(err_uncorr), 0);
    chk({tag, "_scrub_busy"}, 32'(scrub_busy), 0);
    chk({tag, "_scrub_uncorr"}, 32'(scrub_uncorr), 0);
    chk({tag, "_corr_count"}, 32'(corr_count), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int  j;
    int  a;
    int  r;
    bit  found;
    bit  prev;

    j = 0;
    for (int pos = 1; pos < CW; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        dpos[j] = pos;
        j++;
      end
    end
    model_reset();

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("por");
    rst_n = 1'b1;

    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, i, '0, '0);

    step(1'b1, 1'b0, 3, 8'hA5, '0);
    step(1'b0, 1'b1, 3, '0, '0);
    step(1'b1, 1'b0, 5, 8'h3C, 13'(1 << 6));
    step(1'b0, 1'b1, 5, '0, '0);
    step(1'b0, 1'b1, 5, '0, '0);
    step(1'b1, 1'b0, 7, 8'h3C, 13'((1 << 2) | (1 << 9)));
    step(1'b0, 1'b1, 7, '0, '0);
    sweep();
    step(1'b0, 1'b1, 5, '0, '0);
    step(1'b0, 1'b1, 7, '0, '0);
    idle(50);
    chk("scrub_uncorr_sticky", 32'(scrub_uncorr), 32'(m_su));

    // back-to-back host traffic keeps the scrubber stalled, so only host ops change state
    for (int k = 0; k < 600; k++) begin
      r = $urandom_range(9);
      a = $urandom_range(DEPTH - 1);
      if (r < 5)      step(1'b1, 1'b0, a, 8'($urandom), rand_mask());
      else if (r < 9) step(1'b0, 1'b1, a, '0, '0);
      else            step(1'b1, 1'b1, a, 8'($urandom), rand_mask());
    end
    sweep();
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, i, '0, '0);

`ifdef MEM_ERR_INJECT_EN
    rst_n = 1'b0;
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    step(1'b1, 1'b0, 2, 8'h5A, 13'(1 << 4));
    wr_en = 1'b0;
    rd_en = 1'b0;
    found = 1'b0;
    prev  = 1'b0;
    for (int t = 0; t < 200 && !found; t++) begin
      @(negedge clk);
      if (scrub_busy && prev) found = 1'b1;
      else prev = scrub_busy;
    end
    chk("wb_state_seen", 32'(found), 1);
    if (found) begin
      step(1'b1, 1'b0, 2, 8'h11, '0);
      chk("abandon_busy", 32'(scrub_busy), 0);
      idle(3);
      step(1'b0, 1'b1, 2, '0, '0);
    end
`endif

    step(1'b1, 1'b0, 9, 8'h77, 13'(1));
    for (int k = 0; k < 260; k++) step(1'b0, 1'b1, 9, '0, '0);

    wr_en = 1'b0;
    rd_en = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 60 && !found; t++) begin
      @(negedge clk);
      found = scrub_busy;
    end
    chk("busy_before_reset", 32'(found), 1);
    #2 rst_n = 1'b0;
    #1 check_reset("mid_scrub");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, i, '0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
